// File: rtl/sha256_w_window_feeder.sv
// SHA-256 message schedule feeder.
// Streams W0..W63 for one 512-bit block: words 0..15 come straight from the
// loaded message window, words 16..63 are returned by an external one-cycle
// expander that this block feeds with operand taps.
// Optional macro SHA256_FEEDER_SELFCHECK_EN adds an internal recomputation of
// every returned word and a sticky err_o on mismatch; otherwise err_o is 0.
module sha256_w_window_feeder (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic [511:0] msg_i,
  output logic         busy_o,
  output logic [159:0] tap_o,
  output logic         wr_en_o,
  input  logic [31:0]  w_ret_i,
  output logic [31:0]  w_o,
  output logic         w_valid_o,
  output logic [5:0]   w_idx_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [31:0]    win_q [16];
  logic [31:0]    win_d [16];
  logic [159:0]   tap_q, tap_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    w_q, w_d;
  logic           w_valid_q, w_valid_d;
  logic [5:0]     idx_q, idx_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  // Window offset of W[t-16] and the W[t-2] operand for the tap built this cycle
  logic [3:0]     off;
  logic [31:0]    tap_w2;

  // The window only starts sliding once returned words arrive, so the first
  // taps read it at a moving offset and the W[t-2] operand is bypassed from
  // w_ret_i as soon as the word it needs is the one being returned right now.
  always_comb begin
    off    = 4'd2;
    tap_w2 = w_ret_i;
    if (cnt_q < 7'd15) begin
      off    = {2'b00, cnt_q[1:0] - 2'd1};
      tap_w2 = win_q[off + 4'd14];
    end
  end

  // Next-state, window and registered-output computation for the whole block
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    tap_d     = tap_q;
    wr_en_d   = 1'b0;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = 7'd0;
          for (int i = 0; i < 16; i++) win_d[i] = msg_i[511 - 32*i -: 32];
          w_d       = msg_i[511:480];
          idx_d     = 6'd0;
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q >= 7'd15 && cnt_q <= 7'd62) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_ret_i;
        end
        if (cnt_q >= 7'd13 && cnt_q <= 7'd60) begin
          wr_en_d = 1'b1;
          tap_d   = {win_q[off], win_q[off + 4'd1], win_q[off + 4'd9], tap_w2, 32'h0};
        end
        if (cnt_q == 7'd62) done_d = 1'b1;
        if (cnt_q < 7'd63) begin
          w_d   = (cnt_q < 7'd15) ? win_q[cnt_q[3:0] + 4'd1] : w_ret_i;
          idx_d = cnt_q[5:0] + 6'd1;
        end else begin
          state_d   = IDLE;
          w_valid_d = 1'b0;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared immediately by the active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      tap_q     <= '0;
      wr_en_q   <= 1'b0;
      w_q       <= '0;
      w_valid_q <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      tap_q     <= tap_d;
      wr_en_q   <= wr_en_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign tap_o     = tap_q;
  assign wr_en_o   = wr_en_q;
  assign w_o       = w_q;
  assign w_valid_o = w_valid_q;
  assign w_idx_o   = idx_q;
  assign done_o    = done_q;

`ifdef SHA256_FEEDER_SELFCHECK_EN
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  logic        chk_pend_q, chk_pend_d;
  logic [31:0] chk_exp_q, chk_exp_d;
  logic        err_q, err_d;

  // Recompute the word for the tap on the bus and compare it when it returns
  always_comb begin
    chk_pend_d = wr_en_q;
    chk_exp_d  = tap_q[159:128] + sig0(tap_q[127:96]) + tap_q[95:64] + sig1(tap_q[63:32]);
    err_d      = err_q | (chk_pend_q & (w_ret_i != chk_exp_q));
  end

  // Checker registers; the error flag stays set until reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chk_pend_q <= 1'b0;
      chk_exp_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      chk_pend_q <= chk_pend_d;
      chk_exp_q  <= chk_exp_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/sha256_w_window_feeder.md
SHA256_W_WINDOW_FEEDER -- requirements
Module: sha256_w_window_feeder

Interface
REQ-001 CLK  input  1  rising-edge clock.
REQ-002 RST  input  1  reset, asynchronous, active-low.
REQ-003 start_i  input  1  request to load msg_i; sampled only in IDLE.
REQ-004 msg_i  input  512  message block, W0 at [511:480], W15 at [31:0].
REQ-005 busy_o  output  1  high while a block is in progress.
REQ-006 tap_o  output  160  expander operands {W[t-16], W[t-15], W[t-7], W[t-2], 32'h0}, MSB first.
REQ-007 wr_en_o  output  1  expander write enable; high only in tap-issue cycles.
REQ-008 w_ret_i  input  32  registered expander result, W[t], valid one cycle after its tap issue.
REQ-009 w_o  output  32  schedule word W[c].
REQ-010 w_valid_o  output  1  w_o/w_idx_o valid.
REQ-011 w_idx_o  output  6  index c of w_o.
REQ-012 done_o  output  1  one-cycle pulse with W63.
REQ-013 err_o  output  1  sticky self-check mismatch (see Configuration).

Function
REQ-014 States IDLE, RUN; IDLE->RUN on start_i=1 in IDLE (accept cycle N); RUN->IDLE at end of cycle N+64.
REQ-015 At accept, the 16-word window SHALL load msg_i and a 7-bit counter SHALL clear to 0.
REQ-016 In cycle N+1+c, c=0..63: w_valid_o=1, w_idx_o=c, w_o=W[c]; 64 consecutive words, no bubbles.
REQ-017 Words 0..15 SHALL come from the loaded window; words 16..63 SHALL be w_ret_i captured on the edge ending cycle N+c.
REQ-018 Taps for t=16..63 SHALL be issued in cycle N+t-1 with wr_en_o=1; wr_en_o=0 in all other cycles.
REQ-019 The captured W[t-2] SHALL be in the window in time for issue cycle N+t-1; 1-cycle expander latency is fixed, no stall.
REQ-020 Expander arithmetic is mod 2^32: W[t]=W[t-16]+s0(W[t-15])+W[t-7]+s1(W[t-2]).
REQ-021 done_o=1 only in cycle N+64; busy_o=1 in cycles N+1..N+64.
REQ-022 start_i while busy_o=1, including in the done_o cycle, SHALL be ignored, with no effect on state or window.
REQ-023 Outside RUN: w_valid_o=0, wr_en_o=0, tap_o holds its last value, w_o holds its last value.

Reset
REQ-024 RST=0 SHALL force IDLE, counter=0, window=0, tap_o=0, w_o=0, w_idx_o=0, and busy_o, w_valid_o, wr_en_o, done_o, err_o all 0, immediately.
REQ-025 Reset mid-block SHALL abandon the block; no done_o; after release only a new start_i is honoured.

Configuration
REQ-026 Macro SHA256_FEEDER_SELFCHECK_EN defined: the block SHALL compute W[t] internally from each issued tap.
REQ-027 With the self-check, the block SHALL compare that result against w_ret_i in the capture cycle, and on mismatch set err_o, held until reset.
REQ-028 Macro undefined: no checker logic; err_o tied 0.

Verification
REQ-029 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), start -> idx 0..63 contiguous from N+1; W16=0x61626380, W17=0x000F0000; done_o at N+64 only.
REQ-030 Same block with a golden expander model -> all 48 wr_en_o pulses at N+15..N+62; tap_o at N+15 = {0x61626380, 0x0, 0x0, 0x0, 0x0}.
REQ-031 start_i held high for 70 cycles -> exactly one block; the second block is accepted only in IDLE (N+65), with first word at N+66.
REQ-032 RST low at N+30 -> all outputs 0 immediately, no done_o; new start after release -> W0 correct at accept+1.
REQ-033 With SHA256_FEEDER_SELFCHECK_EN, w_ret_i forced XOR 0x1 at t=40 -> err_o=1 from N+41 and held; without the macro -> err_o stays 0.
REQ-034 Two back-to-back blocks with random msg_i -> both 64-word streams match the golden model and the idle gap is exactly one cycle.
